// File: rtl/bp_cache_req_arbiter_if.sv
// Bundle of the I$/D$ request ports and the memory-side request channel of bp_cache_req_arbiter.
// Handshake: a source transfer happens on a rising clock edge where its req_v and req_ready are both 1;
// mem_req_v_o, once raised, holds with a stable payload until a rising edge sees mem_req_ready_i=1.
interface bp_cache_req_arbiter_if #(
  parameter int req_width_p      = 128,
  parameter int metadata_width_p = 8
);
  logic [req_width_p-1:0]      icache_req_i;
  logic                        icache_req_v_i;
  logic                        icache_req_ready_o;
  logic [metadata_width_p-1:0] icache_req_metadata_i;
  logic                        icache_req_metadata_v_i;
  logic                        icache_req_complete_o;

  logic [req_width_p-1:0]      dcache_req_i;
  logic                        dcache_req_v_i;
  logic                        dcache_req_ready_o;
  logic [metadata_width_p-1:0] dcache_req_metadata_i;
  logic                        dcache_req_metadata_v_i;
  logic                        dcache_req_complete_o;

  logic [req_width_p-1:0]      mem_req_o;
  logic                        mem_req_src_o;
  logic [metadata_width_p-1:0] mem_req_metadata_o;
  logic                        mem_req_v_o;
  logic                        mem_req_ready_i;
  logic                        mem_resp_v_i;

  logic                        busy_o;
  logic                        err_o;
  logic [2:0]                  state_dbg;

  modport slave (
    input  icache_req_i, icache_req_v_i, icache_req_metadata_i, icache_req_metadata_v_i,
    input  dcache_req_i, dcache_req_v_i, dcache_req_metadata_i, dcache_req_metadata_v_i,
    input  mem_req_ready_i, mem_resp_v_i,
    output icache_req_ready_o, icache_req_complete_o,
    output dcache_req_ready_o, dcache_req_complete_o,
    output mem_req_o, mem_req_src_o, mem_req_metadata_o, mem_req_v_o,
    output busy_o, err_o, state_dbg
  );

  modport master (
    output icache_req_i, icache_req_v_i, icache_req_metadata_i, icache_req_metadata_v_i,
    output dcache_req_i, dcache_req_v_i, dcache_req_metadata_i, dcache_req_metadata_v_i,
    output mem_req_ready_i, mem_resp_v_i,
    input  icache_req_ready_o, icache_req_complete_o,
    input  dcache_req_ready_o, dcache_req_complete_o,
    input  mem_req_o, mem_req_src_o, mem_req_metadata_o, mem_req_v_o,
    input  busy_o, err_o, state_dbg
  );
endinterface

// File: rtl/bp_cache_req_arbiter.sv
// Serialises I$ and D$ miss requests onto one memory request channel, one request outstanding.
// Optional grant counters are enabled by defining BP_CACHE_REQ_ARB_PERF_EN.
module bp_cache_req_arbiter #(
  parameter int req_width_p      = 128,
  parameter int metadata_width_p = 8
) (
  input logic clk_i,
  input logic reset_i,
  bp_cache_req_arbiter_if.slave bus
`ifdef BP_CACHE_REQ_ARB_PERF_EN
  ,
  output logic [31:0] icache_grant_cnt_o,
  output logic [31:0] dcache_grant_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_META = 3'd1,
    SEND      = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic                        prio_q;  // 1 = D$ wins a tie
  logic                        src_q;
  logic [req_width_p-1:0]      req_q;
  logic [metadata_width_p-1:0] meta_q;
  logic                        err_q;

  logic ready_i, ready_d;
  logic grant_i, grant_d;
  logic meta_hit;

  // Ready is also held low while reset is asserted so every output is 0 during reset.
  always_comb begin
    ready_i  = (state_q == IDLE) && !reset_i && (!prio_q || !bus.dcache_req_v_i);
    ready_d  = (state_q == IDLE) && !reset_i && (prio_q || !bus.icache_req_v_i);
    grant_i  = bus.icache_req_v_i && ready_i;
    grant_d  = bus.dcache_req_v_i && ready_d;
    meta_hit = src_q ? bus.dcache_req_metadata_v_i : bus.icache_req_metadata_v_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_i || grant_d)   state_d = WAIT_META;
      WAIT_META: if (meta_hit)             state_d = SEND;
      SEND:      if (bus.mem_req_ready_i)  state_d = WAIT_RESP;
      WAIT_RESP: if (bus.mem_resp_v_i)     state_d = DONE;
      DONE:                                state_d = IDLE;
      default:                             state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.icache_req_ready_o    = ready_i;
    bus.dcache_req_ready_o    = ready_d;
    bus.mem_req_v_o           = (state_q == SEND);
    bus.icache_req_complete_o = (state_q == DONE) && !src_q;
    bus.dcache_req_complete_o = (state_q == DONE) && src_q;
    bus.busy_o                = (state_q != IDLE);
    bus.err_o                 = err_q;
    bus.mem_req_o             = req_q;
    bus.mem_req_src_o         = src_q;
    bus.mem_req_metadata_o    = meta_q;
    bus.state_dbg             = state_q;
  end

  // Priority passes to the source that was not just granted.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prio_q <= 1'b1;
      src_q  <= 1'b0;
      req_q  <= '0;
      meta_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        req_q  <= grant_d ? bus.dcache_req_i : bus.icache_req_i;
        src_q  <= grant_d;
        prio_q <= !grant_d;
      end
      if ((state_q == WAIT_META) && meta_hit)
        meta_q <= src_q ? bus.dcache_req_metadata_i : bus.icache_req_metadata_i;
      if (bus.mem_resp_v_i && (state_q != WAIT_RESP))
        err_q <= 1'b1;
    end
  end

`ifdef BP_CACHE_REQ_ARB_PERF_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      icache_grant_cnt_o <= '0;
      dcache_grant_cnt_o <= '0;
    end else begin
      if (grant_i && (icache_grant_cnt_o != 32'hFFFF_FFFF))
        icache_grant_cnt_o <= icache_grant_cnt_o + 32'd1;
      if (grant_d && (dcache_grant_cnt_o != 32'hFFFF_FFFF))
        dcache_grant_cnt_o <= dcache_grant_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_cache_req_arbiter.sv
// Directed bench for bp_cache_req_arbiter with a transaction-level reference model checked every cycle.
// Define BP_CACHE_REQ_ARB_PERF_EN to also check the grant counters.
module tb_bp_cache_req_arbiter;
  localparam int RW = 128;
  localparam int MW = 8;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  bp_cache_req_arbiter_if #(.req_width_p(RW), .metadata_width_p(MW)) bus ();

`ifdef BP_CACHE_REQ_ARB_PERF_EN
  logic [31:0] icnt, dcnt;
`endif

  bp_cache_req_arbiter #(.req_width_p(RW), .metadata_width_p(MW)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
`ifdef BP_CACHE_REQ_ARB_PERF_EN
    ,
    .icache_grant_cnt_o (icnt),
    .dcache_grant_cnt_o (dcnt)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  task automatic check_b(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0b, expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic check_w(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model: one request tracked as a transaction ----------------
  int              m_owner;        // -1 none, 0 I$, 1 D$
  bit              m_meta_seen, m_acc, m_resp;
  bit              m_prio;         // source that wins a tie
  bit              m_src, m_err;
  logic [RW-1:0]   m_req;
  logic [MW-1:0]   m_meta;
  logic [31:0]     m_icnt, m_dcnt;
  bit              mr_i, mr_d;

  always @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      m_owner = -1; m_meta_seen = 0; m_acc = 0; m_resp = 0;
      m_prio = 1; m_src = 0; m_err = 0; m_req = '0; m_meta = '0;
      m_icnt = '0; m_dcnt = '0;
    end else begin
      if (bus.mem_resp_v_i && !(m_owner >= 0 && m_meta_seen && m_acc && !m_resp)) m_err = 1;
      if (m_owner < 0) begin
        mr_i = (m_prio == 0) || !bus.dcache_req_v_i;
        mr_d = (m_prio == 1) || !bus.icache_req_v_i;
        if (bus.dcache_req_v_i && mr_d) begin
          m_owner = 1; m_src = 1; m_req = bus.dcache_req_i; m_prio = 0;
          if (m_dcnt != 32'hFFFF_FFFF) m_dcnt = m_dcnt + 1;
        end else if (bus.icache_req_v_i && mr_i) begin
          m_owner = 0; m_src = 0; m_req = bus.icache_req_i; m_prio = 1;
          if (m_icnt != 32'hFFFF_FFFF) m_icnt = m_icnt + 1;
        end
        m_meta_seen = 0; m_acc = 0; m_resp = 0;
      end else if (!m_meta_seen) begin
        if (m_owner == 0 && bus.icache_req_metadata_v_i) begin
          m_meta_seen = 1; m_meta = bus.icache_req_metadata_i;
        end else if (m_owner == 1 && bus.dcache_req_metadata_v_i) begin
          m_meta_seen = 1; m_meta = bus.dcache_req_metadata_i;
        end
      end else if (!m_acc) begin
        if (bus.mem_req_ready_i) m_acc = 1;
      end else if (!m_resp) begin
        if (bus.mem_resp_v_i) m_resp = 1;
      end else begin
        m_owner = -1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int icomp = 0, dcomp = 0;
  always @(negedge clk) begin
    if (bus.icache_req_complete_o === 1'b1) icomp++;
    if (bus.dcache_req_complete_o === 1'b1) dcomp++;
    if (chk_en) begin
      check_b("icache_ready", bus.icache_req_ready_o,
              !reset_i && m_owner < 0 && (m_prio == 0 || !bus.dcache_req_v_i));
      check_b("dcache_ready", bus.dcache_req_ready_o,
              !reset_i && m_owner < 0 && (m_prio == 1 || !bus.icache_req_v_i));
      check_b("mem_req_v", bus.mem_req_v_o, m_owner >= 0 && m_meta_seen && !m_acc);
      check_b("icache_complete", bus.icache_req_complete_o, m_owner == 0 && m_resp);
      check_b("dcache_complete", bus.dcache_req_complete_o, m_owner == 1 && m_resp);
      check_b("busy", bus.busy_o, m_owner >= 0);
      check_b("err", bus.err_o, m_err);
      check_b("mem_req_src", bus.mem_req_src_o, m_src);
      check_w("mem_req", bus.mem_req_o, m_req);
      check_w("mem_req_meta", RW'(bus.mem_req_metadata_o), RW'(m_meta));
`ifdef BP_CACHE_REQ_ARB_PERF_EN
      check_w("icache_grant_cnt", RW'(icnt), RW'(m_icnt));
      check_w("dcache_grant_cnt", RW'(dcnt), RW'(m_dcnt));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.icache_req_i = '0; bus.icache_req_v_i = 0;
    bus.icache_req_metadata_i = '0; bus.icache_req_metadata_v_i = 0;
    bus.dcache_req_i = '0; bus.dcache_req_v_i = 0;
    bus.dcache_req_metadata_i = '0; bus.dcache_req_metadata_v_i = 0;
    bus.mem_req_ready_i = 0; bus.mem_resp_v_i = 0;
  endtask

  task automatic wait_grant();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (bus.busy_o === 1'b1) ok = 1;
    end
    check_b("grant_timeout", ok, 1'b1);
  endtask

  // Metadata for the granted source arrives `delay` cycles after the grant; the other
  // source may wiggle its metadata valid meanwhile.
  task automatic give_meta(input int delay, input logic [MW-1:0] meta, input bit noise);
    bit s;
    s = bus.mem_req_src_o;
    bus.icache_req_metadata_i = s ? ~meta : meta;
    bus.dcache_req_metadata_i = s ? meta : ~meta;
    for (int i = 1; i < delay; i++) begin
      if (noise) begin
        if (s) bus.icache_req_metadata_v_i = 1; else bus.dcache_req_metadata_v_i = 1;
      end
      tick();
    end
    bus.icache_req_metadata_v_i = !s;
    bus.dcache_req_metadata_v_i = s;
    tick();
    bus.icache_req_metadata_v_i = 0;
    bus.dcache_req_metadata_v_i = 0;
  endtask

  task automatic accept(input int bp);
    repeat (bp) tick();
    bus.mem_req_ready_i = 1; tick(); bus.mem_req_ready_i = 0;
  endtask

  task automatic respond(input int delay);
    for (int i = 1; i < delay; i++) tick();
    bus.mem_resp_v_i = 1; tick(); bus.mem_resp_v_i = 0;
    tick();
  endtask

  task automatic single_req(input bit s, input logic [RW-1:0] req, input logic [MW-1:0] meta);
    if (s) begin bus.dcache_req_i = req; bus.dcache_req_v_i = 1; end
    else   begin bus.icache_req_i = req; bus.icache_req_v_i = 1; end
    wait_grant();
    bus.icache_req_v_i = 0; bus.dcache_req_v_i = 0;
    give_meta(1, meta, 0);
    accept(0);
    respond(1);
  endtask

  // Both sources held valid; starting from D$ priority the grants must alternate D$, I$, ...
  task automatic contention(input int n);
    int ic0, dc0, ni, nd;
    ic0 = icomp; dc0 = dcomp; ni = 0; nd = 0;
    bus.icache_req_i = 128'h1111; bus.dcache_req_i = 128'h2222;
    bus.icache_req_v_i = 1; bus.dcache_req_v_i = 1;
    for (int k = 0; k < n; k++) begin
      wait_grant();
      if (k == n - 1) begin bus.icache_req_v_i = 0; bus.dcache_req_v_i = 0; end
      check_b("grant_order", bus.mem_req_src_o, (k % 2) == 0);
      if (k % 2 == 0) nd++; else ni++;
      give_meta(1, MW'(8'h40 + k), 0);
      accept(0);
      respond(1);
    end
    check_w("contention_icomp", RW'(icomp - ic0), RW'(ni));
    check_w("contention_dcomp", RW'(dcomp - dc0), RW'(nd));
  endtask

  // ---------------- test sequence ----------------
  int ic0, dc0;
  initial begin
    idle_inputs();
    reset_i = 0;
    #2 reset_i = 1;
    #1;
    check_b("rst_mem_req_v", bus.mem_req_v_o, 0);
    check_b("rst_busy", bus.busy_o, 0);
    check_b("rst_err", bus.err_o, 0);
    check_w("rst_mem_req", bus.mem_req_o, '0);
    check_b("rst_src", bus.mem_req_src_o, 0);
    check_b("rst_icache_ready", bus.icache_req_ready_o, 0);
    check_b("rst_dcache_ready", bus.dcache_req_ready_o, 0);
    chk_en = 1;
    repeat (2) tick();
    reset_i = 0;

    // First contention after reset: D$ must win first.
    contention(3);

    // Single I$ request with literal payload checks.
    ic0 = icomp; dc0 = dcomp;
    bus.icache_req_i = 128'hA5; bus.icache_req_v_i = 1;
    wait_grant();
    bus.icache_req_v_i = 0;
    give_meta(1, 8'h3, 0);
    check_b("single_v", bus.mem_req_v_o, 1);
    check_w("single_req", bus.mem_req_o, 128'hA5);
    check_b("single_src", bus.mem_req_src_o, 0);
    check_w("single_meta", RW'(bus.mem_req_metadata_o), RW'(8'h3));
    accept(0);
    respond(2);
    check_w("single_icomp", RW'(icomp - ic0), RW'(1));
    check_w("single_dcomp", RW'(dcomp - dc0), RW'(0));

    // Backpressure: payload held, sources not ready.
    bus.dcache_req_i = 128'hBEEF_0000_1234; bus.dcache_req_v_i = 1;
    wait_grant();
    bus.dcache_req_v_i = 0;
    give_meta(1, 8'h5A, 0);
    bus.icache_req_i = 128'h77; bus.icache_req_v_i = 1;
    for (int i = 0; i < 10; i++) begin
      check_b("bp_v", bus.mem_req_v_o, 1);
      check_w("bp_req", bus.mem_req_o, 128'hBEEF_0000_1234);
      check_b("bp_icache_ready", bus.icache_req_ready_o, 0);
      check_b("bp_dcache_ready", bus.dcache_req_ready_o, 0);
      tick();
    end
    bus.icache_req_v_i = 0;
    accept(0);
    respond(1);

    // Metadata five cycles after the grant, with the other source's metadata valid as noise.
    bus.icache_req_i = 128'hC0DE; bus.icache_req_v_i = 1;
    wait_grant();
    bus.icache_req_v_i = 0;
    bus.icache_req_metadata_i = 8'h77; bus.dcache_req_metadata_i = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      bus.dcache_req_metadata_v_i = 1;
      check_b("meta_wait_v", bus.mem_req_v_o, 0);
      tick();
    end
    bus.dcache_req_metadata_v_i = 0;
    bus.icache_req_metadata_v_i = 1;
    check_b("meta_arrive_v", bus.mem_req_v_o, 0);
    tick();
    bus.icache_req_metadata_v_i = 0;
    check_b("meta_after_v", bus.mem_req_v_o, 1);
    check_w("meta_value", RW'(bus.mem_req_metadata_o), RW'(8'h77));
    accept(0);
    respond(1);

    // Stray response in IDLE.
    ic0 = icomp; dc0 = dcomp;
    bus.mem_resp_v_i = 1; tick(); bus.mem_resp_v_i = 0;
    check_b("stray_err", bus.err_o, 1);
    repeat (3) tick();
    check_b("stray_err_sticky", bus.err_o, 1);
    check_w("stray_no_complete", RW'((icomp - ic0) + (dcomp - dc0)), RW'(0));
    single_req(1, 128'hD00D, 8'h11);
    check_b("stray_err_after", bus.err_o, 1);
    check_w("stray_dcomp", RW'(dcomp - dc0), RW'(1));

    // Reset while a request waits for its response.
    ic0 = icomp; dc0 = dcomp;
    bus.icache_req_i = 128'h99; bus.icache_req_v_i = 1;
    wait_grant();
    bus.icache_req_v_i = 0;
    give_meta(1, 8'h22, 0);
    accept(0);
    bus.icache_req_v_i = 1; bus.dcache_req_v_i = 1;
    bus.icache_req_i = 128'h1111; bus.dcache_req_i = 128'h2222;
    #2 reset_i = 1;
    #1;
    check_b("midrst_busy", bus.busy_o, 0);
    check_b("midrst_err", bus.err_o, 0);
    check_b("midrst_icache_ready", bus.icache_req_ready_o, 0);
    check_b("midrst_dcache_ready", bus.dcache_req_ready_o, 0);
    check_w("midrst_req", bus.mem_req_o, '0);
    repeat (2) tick();
    reset_i = 0;
    check_w("midrst_no_complete", RW'((icomp - ic0) + (dcomp - dc0)), RW'(0));
    contention(4);
    single_req(1, 128'h3333, 8'h44);
`ifdef BP_CACHE_REQ_ARB_PERF_EN
    check_w("perf_dcnt", RW'(dcnt), RW'(32'd3));
    check_w("perf_icnt", RW'(icnt), RW'(32'd2));
`endif
    repeat (2) tick();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
